serial_sub: RTL

Parametrised multi-cycle subtractor computing `a - b - bin` on WIDTH-bit operands, CHUNK bits per clock, LSB chunk first, with borrow carried between cycles. It generalises the single-bit full subtractor into a registered, handshaked datapath unit for arithmetic pipelines where a full-width ripple borrow chain would not meet timing. Operands are latched on acceptance. The result is held until the consumer takes it.

---
 rtl/serial_sub_pkg.sv | 23 ++
 rtl/serial_sub_chunk_sub.sv | 34 +++
 rtl/serial_sub.sv | 138 +++++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg
// Shared definitions for the serial subtractor:
//   - state_e      : controller state encoding (IDLE / RUN / DONE)
//   - nchunk()     : number of CHUNK-bit slices in a WIDTH-bit operand
//   - idx_width()  : width of the chunk index counter (at least 1 bit)
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A counter for a single chunk still needs one bit to exist.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_sub_chunk_sub.sv
// chunk_sub
// Combinational W-bit ripple subtractor built from per-bit full-subtractor
// equations: d = a ^ b ^ bin, bout = (~a & b) | (~(a ^ b) & bin).
// Ports:
//   a_i, b_i  [W-1:0] : minuend / subtrahend slice
//   bin_i             : borrow into bit 0 of the slice
//   d_o       [W-1:0] : difference slice
//   bmsb_o            : borrow into the slice MSB (for signed overflow)
//   bout_o            : borrow out of the slice MSB
module chunk_sub #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         bin_i,
  output logic [W-1:0] d_o,
  output logic         bmsb_o,
  output logic         bout_o
);

  // borrow[i] is the borrow into bit i; borrow[W] leaves the slice.
  logic [W:0] borrow;

  assign borrow[0] = bin_i;

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    assign d_o[gi]        = a_i[gi] ^ b_i[gi] ^ borrow[gi];
    assign borrow[gi + 1] = (~a_i[gi] & b_i[gi]) | (~(a_i[gi] ^ b_i[gi]) & borrow[gi]);
  end

  assign bmsb_o = borrow[W-1];
  assign bout_o = borrow[W];

endmodule

// File: rtl/serial_sub.sv
// serial_sub
// Multi-cycle subtractor computing (a - b - bin) mod 2^WIDTH, CHUNK bits per
// clock, LSB chunk first, with the borrow carried between cycles. Operands
// are latched on acceptance; the result is held until the consumer takes it.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the signed-overflow output.
// Ports:
//   clk, rst              : clock and synchronous active-high reset
//   in_valid / in_ready   : operand handshake (ready only when idle)
//   a, b [WIDTH-1:0], bin : minuend, subtrahend, borrow-in
//   out_valid / out_ready : result handshake (valid only when done)
//   diff [WIDTH-1:0]      : difference
//   bout                  : unsigned borrow-out (a < b + bin)
//   ovf                   : two's-complement overflow (SERIAL_SUB_OVF_EN only)
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IDXW   = idx_width(NCHUNK);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_cfg_check
    $error("serial_sub: WIDTH must be a positive multiple of CHUNK");
  end

  state_e           state_q;
  logic [IDXW-1:0]  idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             borrow_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q;
  logic             chunk_bmsb;
`else
  logic             unused_chunk_bmsb;
`endif

  // Slice of the latched operands addressed by the chunk index.
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK-1:0] chunk_d;
  logic             chunk_bout;

  assign chunk_a = a_q[int'(idx_q)*CHUNK +: CHUNK];
  assign chunk_b = b_q[int'(idx_q)*CHUNK +: CHUNK];

  chunk_sub #(
    .W(CHUNK)
  ) u_chunk_sub (
    .a_i   (chunk_a),
    .b_i   (chunk_b),
    .bin_i (borrow_q),
    .d_o   (chunk_d),
`ifdef SERIAL_SUB_OVF_EN
    .bmsb_o(chunk_bmsb),
`else
    .bmsb_o(unused_chunk_bmsb),
`endif
    .bout_o(chunk_bout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= bin;  // borrow-in seeds the chain at chunk 0
            idx_q    <= '0;
            state_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          diff_q[int'(idx_q)*CHUNK +: CHUNK] <= chunk_d;
          borrow_q <= chunk_bout;
          if (idx_q == LAST_IDX) begin
            bout_q  <= chunk_bout;
`ifdef SERIAL_SUB_OVF_EN
            // Signed overflow: borrow into the MSB differs from borrow out of it.
            ovf_q   <= chunk_bmsb ^ chunk_bout;
`endif
            state_q <= ST_DONE;
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Handshake flags decode straight from the state register.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
